// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline definitions: datapath width, writeback result-select
// encodings and load funct3 codes.
package rv32_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_RSV = 2'b11
  } result_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Load data alignment: picks the byte/halfword addressed by off out of an
// aligned little-endian word and sign- or zero-extends it per funct3.
module load_extend
  import rv32_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] value
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = word[{off, 3'b000} +: 8];
  // Halfword selection ignores off[0]; misaligned halfwords are not trapped here.
  assign half_v = off[1] ? word[31:16] : word[15:0];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    value = word;
    case (funct3)
      F3_LB:   value = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_LBU:  value = {{(XLEN-8){1'b0}}, byte_v};
      F3_LH:   value = {{(XLEN-16){half_v[15]}}, half_v};
      F3_LHU:  value = {{(XLEN-16){1'b0}}, half_v};
      default: value = word;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and writeback result selection for the RV32I pipeline.
// Optional retired-instruction counter (InstRetW) enabled by WB_RETIRE_CNT_EN.
module writeback_stage
  import rv32_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallW,
  input  logic            FlushW,
  input  logic            ValidM,
  input  logic            RegWriteM,
  input  logic [1:0]      ResultSrcM,
  input  logic [2:0]      funct3M,
  input  logic [4:0]      RdM,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] ReadDataM,
  input  logic [XLEN-1:0] PCPlus4M,
  output logic            RegWriteW,
  output logic [4:0]      RdW,
  output logic [XLEN-1:0] ResultW,
  output logic            ValidW
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0] InstRetW
`endif
);

  if (XLEN != 32 || CNT_W < 1) begin : g_param_check
    $error("writeback_stage supports only XLEN=32 and CNT_W>=1");
  end

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    result_src_e     result_src;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] read_data;
    logic [XLEN-1:0] pc_plus4;
  } mem_wb_t;

  mem_wb_t         wb_q;
  logic            capture;
  logic [XLEN-1:0] load_value;

  assign capture = !FlushW && !StallW;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || FlushW) begin
      wb_q <= '0;
    end else if (!StallW) begin
      wb_q.valid      <= ValidM;
      wb_q.reg_write  <= RegWriteM;
      wb_q.result_src <= result_src_e'(ResultSrcM);
      wb_q.funct3     <= funct3M;
      wb_q.rd         <= RdM;
      wb_q.alu_result <= ALUResultM;
      wb_q.read_data  <= ReadDataM;
      wb_q.pc_plus4   <= PCPlus4M;
    end
  end

  load_extend u_load_extend (
    .word   (wb_q.read_data),
    .off    (wb_q.alu_result[1:0]),
    .funct3 (wb_q.funct3),
    .value  (load_value)
  );

  always_comb begin
    ResultW = wb_q.alu_result;
    case (wb_q.result_src)
      RES_MEM: ResultW = load_value;
      RES_PC4: ResultW = wb_q.pc_plus4;
      default: ResultW = wb_q.alu_result;
    endcase
  end

  // Writes to x0 are suppressed here so forwarding never sees a live x0 producer.
  assign RegWriteW = wb_q.reg_write && wb_q.valid && (wb_q.rd != 5'd0);
  assign RdW       = wb_q.rd;
  assign ValidW    = wb_q.valid;

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] inst_ret_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_ret_q <= '0;
    end else if (capture && ValidM) begin
      inst_ret_q <= inst_ret_q + CNT_W'(1);
    end
  end

  assign InstRetW = inst_ret_q;
`else
  logic unused_capture;
  assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: spec vectors, stall/flush/counter
// sequences and randomized traffic against a transaction-level reference model.
module tb_writeback_stage;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        rst, StallW, FlushW, ValidM, RegWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  funct3M;
  logic [4:0]  RdM;
  logic [31:0] ALUResultM, ReadDataM, PCPlus4M;
  logic        RegWriteW, ValidW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk(clk), .rst(rst), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .funct3M(funct3M), .RdM(RdM),
    .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .ValidW(ValidW)
`ifdef WB_RETIRE_CNT_EN
    , .InstRetW(inst_ret)
`endif
  );

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] inst_ret;
  logic [2:0]  inst_ret_small;
  logic        s_rw, s_valid;
  logic [4:0]  s_rd;
  logic [31:0] s_res;

  // Narrow-counter copy makes the all-ones -> 0 wrap reachable in a few cycles.
  writeback_stage #(.CNT_W(3)) dut_small (
    .clk(clk), .rst(rst), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .funct3M(funct3M), .RdM(RdM),
    .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M),
    .RegWriteW(s_rw), .RdW(s_rd), .ResultW(s_res), .ValidW(s_valid),
    .InstRetW(inst_ret_small)
  );
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit        valid;
    bit        rw;
    bit [1:0]  src;
    bit [2:0]  f3;
    bit [4:0]  rd;
    bit [31:0] alu;
    bit [31:0] rdata;
    bit [31:0] pc4;
  } txn_t;

  txn_t            m;        // instruction the model says is in WB
  longint unsigned exp_cnt;  // retired instructions per the model

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit [31:0] ref_load(input bit [31:0] rdata, input int off, input bit [2:0] f3);
    bit [31:0] b, h;
    b = (rdata >> (8 * off)) % 256;
    h = (rdata >> (16 * (off / 2))) % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      default: return rdata;
    endcase
  endfunction

  function automatic bit [31:0] ref_result(input txn_t t);
    case (t.src)
      2'd1:    return ref_load(t.rdata, int'(t.alu % 4), t.f3);
      2'd2:    return t.pc4;
      default: return t.alu;
    endcase
  endfunction

  task automatic drive(input bit v, input bit rw, input bit [1:0] src, input bit [2:0] f3,
                       input bit [4:0] rd, input bit [31:0] alu, input bit [31:0] rdata,
                       input bit [31:0] pc4);
    ValidM = v; RegWriteM = rw; ResultSrcM = src; funct3M = f3; RdM = rd;
    ALUResultM = alu; ReadDataM = rdata; PCPlus4M = pc4;
  endtask

  // Advance the model from the stable inputs, then let the DUT see the same edge.
  task automatic tick();
    if (rst) begin
      m = '{default: 0};
      exp_cnt = 0;
    end else if (FlushW) begin
      m = '{default: 0};
    end else if (!StallW) begin
      m = '{valid: ValidM, rw: RegWriteM, src: ResultSrcM, f3: funct3M, rd: RdM,
            alu: ALUResultM, rdata: ReadDataM, pc4: PCPlus4M};
      if (ValidM) exp_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".ValidW"},    ValidW,    m.valid);
    check({tag, ".RdW"},       RdW,       m.rd);
    check({tag, ".ResultW"},   ResultW,   ref_result(m));
    check({tag, ".RegWriteW"}, RegWriteW, m.rw && m.valid && (m.rd != 0));
`ifdef WB_RETIRE_CNT_EN
    check({tag, ".InstRetW"},  inst_ret,       exp_cnt);
    check({tag, ".InstRetS"},  inst_ret_small, exp_cnt % 8);
`endif
  endtask

  typedef struct {
    bit [1:0]  src;
    bit [2:0]  f3;
    bit [4:0]  rd;
    bit [31:0] alu;
    bit [31:0] rdata;
    bit [31:0] pc4;
    bit [31:0] exp_res;
    bit        exp_rw;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{2'b01, 3'b000, 5'd3, 32'h1003, 32'h80FF1234, 32'h0,   32'hFFFFFF80, 1'b1};
    vecs[1]  = '{2'b01, 3'b100, 5'd3, 32'h1003, 32'h80FF1234, 32'h0,   32'h00000080, 1'b1};
    vecs[2]  = '{2'b01, 3'b000, 5'd4, 32'h1001, 32'h80FF1234, 32'h0,   32'h00000012, 1'b1};
    vecs[3]  = '{2'b01, 3'b001, 5'd5, 32'h2002, 32'h80017FFF, 32'h0,   32'hFFFF8001, 1'b1};
    vecs[4]  = '{2'b01, 3'b101, 5'd5, 32'h2002, 32'h80017FFF, 32'h0,   32'h00008001, 1'b1};
    vecs[5]  = '{2'b01, 3'b001, 5'd6, 32'h2000, 32'h80017FFF, 32'h0,   32'h00007FFF, 1'b1};
    vecs[6]  = '{2'b01, 3'b001, 5'd6, 32'h2003, 32'h80017FFF, 32'h0,   32'hFFFF8001, 1'b1};
    vecs[7]  = '{2'b01, 3'b010, 5'd7, 32'h2002, 32'h80017FFF, 32'h0,   32'h80017FFF, 1'b1};
    vecs[8]  = '{2'b10, 3'b000, 5'd1, 32'h55,   32'h0,        32'h104, 32'h00000104, 1'b1};
    vecs[9]  = '{2'b10, 3'b000, 5'd0, 32'h55,   32'h0,        32'h104, 32'h00000104, 1'b0};
    vecs[10] = '{2'b00, 3'b000, 5'd9, 32'hDEADBEEF, 32'h1234, 32'h8,   32'hDEADBEEF, 1'b1};
    vecs[11] = '{2'b11, 3'b000, 5'd9, 32'h55,   32'h1234,     32'h8,   32'h00000055, 1'b1};
    vecs[12] = '{2'b01, 3'b011, 5'd9, 32'h1001, 32'hCAFEF00D, 32'h8,   32'hCAFEF00D, 1'b1};

    m = '{default: 0};
    exp_cnt = 0;
    StallW = 1'b0; FlushW = 1'b0;

    // Reset held two cycles with a live instruction on the inputs.
    rst = 1'b1;
    drive(1'b1, 1'b1, 2'b00, 3'b000, 5'd5, 32'h1234, 32'h5678, 32'h9ABC);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst.RegWriteW", RegWriteW, 0);
      check("rst.RdW",       RdW,       0);
      check("rst.ResultW",   ResultW,   0);
      check("rst.ValidW",    ValidW,    0);
`ifdef WB_RETIRE_CNT_EN
      check("rst.InstRetW",  inst_ret,  0);
`endif
    end
    rst = 1'b0;

    // Spec vectors: one-cycle latency, result selection and x0 gating.
    foreach (vecs[i]) begin
      drive(1'b1, 1'b1, vecs[i].src, vecs[i].f3, vecs[i].rd, vecs[i].alu, vecs[i].rdata, vecs[i].pc4);
      tick();
      check($sformatf("vec%0d.ResultW", i),   ResultW,   vecs[i].exp_res);
      check($sformatf("vec%0d.RegWriteW", i), RegWriteW, vecs[i].exp_rw);
      check($sformatf("vec%0d.RdW", i),       RdW,       vecs[i].rd);
      check_model($sformatf("vec%0d.model", i));
    end

    // Stall holds the captured ALU result while inputs move on.
    drive(1'b1, 1'b1, 2'b00, 3'b000, 5'd2, 32'hA, 32'h0, 32'h0);
    tick();
    check("stall.pre", ResultW, 32'hA);
    StallW = 1'b1;
    drive(1'b1, 1'b1, 2'b00, 3'b000, 5'd3, 32'hB, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall%0d.ResultW", i), ResultW, 32'hA);
      check($sformatf("stall%0d.RdW", i),     RdW,     5'd2);
    end
    // Flush wins over a simultaneous stall.
    FlushW = 1'b1;
    tick();
    check("flush.ValidW",    ValidW,    0);
    check("flush.RegWriteW", RegWriteW, 0);
    check_model("flush.model");
    StallW = 1'b0; FlushW = 1'b0;

`ifdef WB_RETIRE_CNT_EN
    // 5 retirements, then a stalled and a flushed instruction that must not count.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 2'b00, 3'b000, 5'(i + 1), 32'(i), 32'h0, 32'h0);
      tick();
    end
    StallW = 1'b1; tick(); StallW = 1'b0;
    FlushW = 1'b1; tick(); FlushW = 1'b0;
    check("cnt.five", inst_ret, 5);
    // Wrap: 7 captures saturate the 3-bit copy, the 8th returns it to 0.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("cnt.allones", inst_ret_small, 3'h7);
    tick();
    check("cnt.wrap", inst_ret_small, 3'h0);
    check("cnt.wide", inst_ret, 8);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst    = ($urandom_range(0, 49) == 0);
      StallW = ($urandom_range(0, 4) == 0);
      FlushW = ($urandom_range(0, 7) == 0);
      drive(1'($urandom), 1'($urandom), 2'($urandom), 3'($urandom), 5'($urandom),
            $urandom, $urandom, $urandom);
      tick();
      check_model($sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- MEM/WB pipeline register plus writeback result selection for the RV32I 5-stage pipeline.
- Captures memory-stage results and performs load byte/halfword extraction with sign/zero extension.
- Drives the register file write port: RegWriteW to WE3, RdW to A3, ResultW to WD3.
- Also exports RdW/ResultW/RegWriteW to the hazard/forwarding unit.

Parameters:
- XLEN, 32, datapath width; only 32 supported.
- CNT_W, 64, width of the retired-instruction counter (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- StallW  in  1  hold the MEM/WB register contents.
- FlushW  in  1  load a bubble into the MEM/WB register.
- ValidM  in  1  a real instruction is in the MEM stage.
- RegWriteM  in  1  the MEM-stage instruction writes rd.
- ResultSrcM  in  2  result select: 00 ALU, 01 load, 10 PC+4, 11 reserved.
- funct3M  in  3  load type.
- RdM  in  5  destination register.
- ALUResultM  in  32  ALU result or load address.
- ReadDataM  in  32  raw aligned 32-bit word from data memory.
- PCPlus4M  in  32  link value.
- RegWriteW  out  1  register file write enable.
- RdW  out  5  register file write address.
- ResultW  out  32  register file write data.
- ValidW  out  1  a real instruction is in WB.

Behaviour:
- Update priority each rising edge: rst > FlushW > StallW > capture.
- rst=1: all registered fields cleared. Outputs then read RegWriteW=0, RdW=0, ResultW=0, ValidW=0.
- FlushW=1: ValidW and the registered RegWrite are cleared; other fields are don't-care but cleared to 0. This applies even if StallW=1 in the same cycle.
- StallW=1 (no flush): all fields hold; outputs stay constant.
- Capture: all M-stage inputs are registered. Latency is 1 cycle (M-stage values in cycle n appear on W outputs in cycle n+1).
- RegWriteW = registered RegWrite AND ValidW AND (RdW != 0). It is combinational from registered state, with no combinational path from M inputs.
- ResultW is combinational from registered fields:
  - 00: ALUResult.
  - 01: extracted load (below).
  - 10: PCPlus4.
  - 11: ALUResult.
- Load extraction uses off = registered ALUResult[1:0] and funct3:
  - 000 LB: byte[off], sign-extended.
  - 100 LBU: byte[off], zero-extended.
  - 001 LH: halfword[off[1]], sign-extended; off[0] ignored (misaligned access is not trapped here).
  - 101 LHU: as LH, zero-extended.
  - 010 LW: full word; off ignored.
  - Other funct3 values: full word.
- Byte 0 is ReadData[7:0] (little-endian).
- Write-before-read within the same cycle is the register file's concern; this block makes no bypass guarantee.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined:
  - Adds output port InstRetW [CNT_W-1:0], a counter reset to 0 by rst.
  - Increments by 1 on each edge where a capture occurs (no rst, no FlushW, no StallW) with ValidM=1.
  - Wraps from all-ones to 0.
  - Holds during stall; flush does not increment.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package rv32_pkg holds:
  - ResultSrc encodings: RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10.
  - Load funct3 constants: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - XLEN.
- One natural sub-module: load_extend, purely combinational. Inputs are word, off[1:0], funct3; output is a 32-bit value. It is reused by any later load/store unit.

Test Plan:
- Reset: hold rst=1 for 2 cycles while RegWriteM=1, RdM=5, ValidM=1 -> RegWriteW=0, RdW=0, ResultW=0, ValidW=0 throughout; InstRetW=0 if WB_RETIRE_CNT_EN is defined.
- Byte loads:
  - ResultSrcM=01, ReadDataM=0x80FF1234, ALUResultM=0x1003, funct3M=000 -> next cycle ResultW=0xFFFFFF80.
  - Same with funct3M=100 -> 0x00000080.
  - Offset 1 with funct3M=000 -> 0x00000012.
- Halfword/word loads, ReadDataM=0x80017FFF:
  - Offset 2, LH -> 0xFFFF8001.
  - Offset 2, LHU -> 0x00008001.
  - Offset 0, LH -> 0x00007FFF.
  - Offset 3, LH -> 0xFFFF8001 (off[0] ignored).
  - LW at offset 2 -> 0x80017FFF.
- Link and x0 gating: ResultSrcM=10, PCPlus4M=0x00000104, RdM=1 -> ResultW=0x104, RegWriteW=1. Repeat with RdM=0 -> RegWriteW=0.
- Stall and flush:
  - Capture ALUResult 0xA, then StallW=1 for 3 cycles while inputs change to 0xB -> ResultW stays 0xA.
  - FlushW=1 and StallW=1 together -> next cycle ValidW=0, RegWriteW=0.
- Retire counter (WB_RETIRE_CNT_EN defined):
  - Feed 5 valid instructions, 1 stalled cycle and 1 flushed instruction -> InstRetW=5.
  - Force the counter to 0xFFFFFFFFFFFFFFFF plus one capture -> 0.
